db_load_responder: RTL and testbench
====================================

Name: db_load_responder

Overview:
- Serves line-load requests from the seed-expansion FSM.
- Takes a level `load` request with a 32-bit bit-address, fetches the 512-bit database line holding that address from the database memory port, and returns it.
- Handshake back to the requester: `loadDone` acknowledge pulse, then `dataValid` with `inDB`.
- Keeps a one-line cache so repeated loads of the same line skip memory.

Parameters:
DATA_W, 512, database line width in bits
LINE_SHIFT, 9, log2(DATA_W); line index = outAddress >> LINE_SHIFT
MEM_AW, 23, memory line-address width
BASE_LINE, 0, memory line offset added to the line index
DB_LINES, 131072, number of valid database lines; indices >= DB_LINES are out of range

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
load  input  1  request level from the expansion FSM
outAddress  input  32  bit address, sampled on the accept cycle
loadDone  output  1  one-cycle request acknowledge
dataValid  output  1  one-cycle data strobe
inDB  output  512  returned line; valid when dataValid=1, held afterwards
mem_rd_req  output  1  memory read request, held until ack
mem_rd_addr  output  MEM_AW  memory line address
mem_rd_ack  input  1  memory accepted request
mem_rd_valid  input  1  read data strobe
mem_rd_data  input  512  read data
db_update  input  1  database rewritten; invalidate cache
hit_count  output  16  saturating cache-hit count
miss_count  output  16  saturating memory-fetch count
err_unexp  output  1  sticky: mem_rd_valid outside a fetch

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; all outputs 0, including inDB and counters.
  - cache invalid; load_q=0.
  - Any memory response already in flight is ignored.
- load_q is the registered copy of `load`.
- Accept: only in IDLE, when load=1 and load_q=0 (rising edge). A level held high after completion does not re-trigger; the requester must drop `load` for at least one cycle between requests.
- On accept, latch line = outAddress[31:LINE_SHIFT] (23 bits). outAddress changes after the accept cycle are ignored.
- States: IDLE, HIT, OOR, REQ, ACK, WAIT_DATA, DELIVER.
- From IDLE on accept, first matching rule wins:
  - line >= DB_LINES -> OOR.
  - cache valid and line == cache_tag -> HIT.
  - otherwise -> REQ.
- HIT / OOR:
  - loadDone=1 for one cycle, then DELIVER.
  - HIT delivers cached data; OOR delivers all zeros.
  - OOR does not touch the cache or counters; HIT increments hit_count.
- REQ:
  - mem_rd_req=1, mem_rd_addr = line + BASE_LINE (mod 2^MEM_AW), stable until mem_rd_ack.
  - On mem_rd_ack: mem_rd_req=0 next cycle, state -> ACK.
- ACK:
  - loadDone=1 for one cycle; increments miss_count.
  - mem_rd_valid in this cycle is captured; otherwise -> WAIT_DATA.
- WAIT_DATA: wait indefinitely for mem_rd_valid.
- Data capture (ACK or WAIT_DATA):
  - inDB <= mem_rd_data; cache_tag <= line; cache valid.
  - -> DELIVER (from ACK, DELIVER follows the ACK cycle).
- DELIVER: dataValid=1 for one cycle, inDB stable, -> IDLE.
- Ordering: dataValid is always at least one cycle after loadDone, and never in the same cycle.
- Latency from the accept edge:
  - hit/OOR: loadDone at +1, dataValid at +2.
  - miss with ack at +1 and valid in the same cycle: loadDone at +2, dataValid at +3.
- db_update:
  - Clears cache valid in any state.
  - If asserted the same cycle as a miss capture, invalidation wins (data delivered, not cached).
  - A HIT already decided still delivers its data.
- mem_rd_valid in IDLE, HIT, OOR, REQ or DELIVER: data ignored, err_unexp=1 (cleared only by reset).
- Counters saturate at 16'hFFFF.
- Simultaneous request and completion: the rising edge is evaluated only in IDLE. A load edge arriving in the DELIVER cycle is lost, so the requester must wait for dataValid.

Test Plan:
- Miss fetch: reset, load rises with outAddress=3*512+10, mem ack 2 cycles later, valid 3 cycles after ack with pattern A -> mem_rd_addr=3; loadDone one pulse; dataValid one cycle later with inDB=A; miss_count=1.
- Cache hit: repeat with outAddress=3*512+300, load dropped one cycle between requests -> no mem_rd_req; loadDone at +1, dataValid at +2, inDB=A; hit_count=1.
- Out of range, zero data: DB_LINES=4, outAddress=5*512 -> loadDone at +1, dataValid at +2 with inDB=0; no memory access; counters unchanged.
- Held load / no retrigger: keep load=1 for 20 cycles after dataValid -> exactly one loadDone; drop load for one cycle and raise -> second request served.
- Invalidate and error: db_update after a fetch, then same line -> memory fetched again (miss_count=2). Stray mem_rd_valid in IDLE -> err_unexp=1, inDB unchanged.
- Reset mid-fetch: rst in WAIT_DATA, then late mem_rd_valid -> outputs 0, no dataValid, state IDLE, cache invalid.

Source files
------------

// File: rtl/db_load_responder.sv
// db_load_responder: serves line-load requests from the seed-expansion FSM.
// A rising edge on `load` latches the line index of outAddress. The line is
// either rejected as out of range (zeros returned), served from a one-line
// cache, or fetched over the memory read port. The requester sees a one-cycle
// loadDone acknowledge, followed at least one cycle later by a one-cycle
// dataValid with the line on inDB.
module db_load_responder #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned LINE_SHIFT = 9,
  parameter int unsigned MEM_AW     = 23,
  parameter int unsigned BASE_LINE  = 0,
  parameter int unsigned DB_LINES   = 131072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [31:0]       outAddress,
  output logic              loadDone,
  output logic              dataValid,
  output logic [DATA_W-1:0] inDB,
  output logic              mem_rd_req,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              db_update,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic              err_unexp
);

  localparam int unsigned LINE_W = 32 - LINE_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE, S_HIT, S_OOR, S_REQ, S_ACK, S_WAIT_DATA, S_DELIVER
  } state_t;

  state_t state_q, state_d;

  logic              load_q;
  logic [LINE_W-1:0] line_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              cache_valid_q;
  logic [LINE_W-1:0] cache_tag_q;
  logic [DATA_W-1:0] cache_data_q;
  logic [DATA_W-1:0] in_db_q;
  logic [15:0]       hit_q;
  logic [15:0]       miss_q;
  logic              err_q;
  // Set by reset and cleared by the next accepted request: a response that
  // was in flight when reset hit may still arrive and must not be flagged.
  logic              drain_q;

  logic [LINE_W-1:0] req_line;
  logic              accept;
  logic              req_oor;
  logic              req_hit;
  logic              fetching;
  logic              capture;
  logic              unused_addr_bits;

  assign req_line = outAddress[31:LINE_SHIFT];
  // Bits below the line boundary only select within the line, which the
  // requester handles itself.
  assign unused_addr_bits = ^outAddress[LINE_SHIFT-1:0];

  assign accept   = (state_q == S_IDLE) && load && !load_q;
  assign req_oor  = 32'(req_line) >= DB_LINES;
  assign req_hit  = cache_valid_q && (cache_tag_q == req_line);
  assign fetching = (state_q == S_ACK) || (state_q == S_WAIT_DATA);
  assign capture  = fetching && mem_rd_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; out-of-range takes priority over a cache hit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_oor)      state_d = S_OOR;
          else if (req_hit) state_d = S_HIT;
          else              state_d = S_REQ;
        end
      end
      S_HIT, S_OOR: state_d = S_DELIVER;
      S_REQ:        if (mem_rd_ack) state_d = S_ACK;
      S_ACK:        state_d = mem_rd_valid ? S_DELIVER : S_WAIT_DATA;
      S_WAIT_DATA:  if (mem_rd_valid) state_d = S_DELIVER;
      S_DELIVER:    state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    loadDone   = 1'b0;
    dataValid  = 1'b0;
    mem_rd_req = 1'b0;
    case (state_q)
      S_HIT, S_OOR, S_ACK: loadDone   = 1'b1;
      S_REQ:               mem_rd_req = 1'b1;
      S_DELIVER:           dataValid  = 1'b1;
      default:             ;
    endcase
  end

  // Request latch: edge detector, line index and memory address
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q     <= 1'b0;
      line_q     <= '0;
      mem_addr_q <= '0;
      drain_q    <= 1'b1;
    end else begin
      load_q <= load;
      if (accept) begin
        line_q     <= req_line;
        mem_addr_q <= MEM_AW'(req_line) + MEM_AW'(BASE_LINE);
        drain_q    <= 1'b0;
      end
    end
  end

  // Returned data and one-line cache; invalidation overrides a same-cycle fill
  always_ff @(posedge clk) begin
    if (rst) begin
      in_db_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      if (state_q == S_HIT) in_db_q <= cache_data_q;
      if (state_q == S_OOR) in_db_q <= '0;
      if (capture) begin
        in_db_q       <= mem_rd_data;
        cache_data_q  <= mem_rd_data;
        cache_tag_q   <= line_q;
        cache_valid_q <= 1'b1;
      end
      if (db_update) cache_valid_q <= 1'b0;
    end
  end

  // Saturating statistics and the sticky stray-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_HIT && hit_q != 16'hFFFF)  hit_q  <= hit_q + 16'd1;
      if (state_q == S_ACK && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      if (mem_rd_valid && !fetching && !drain_q)  err_q  <= 1'b1;
    end
  end

  assign inDB        = in_db_q;
  assign mem_rd_addr = mem_addr_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_db_load_responder.sv
// Testbench for db_load_responder: directed scenarios plus randomized loads,
// checked against a transaction-level model of the line cache and counters.
module tb_db_load_responder;

  localparam int DBL  = 4;
  localparam int BASE = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [31:0]  outAddress;
  logic         loadDone;
  logic         dataValid;
  logic [511:0] inDB;
  logic         mem_rd_req;
  logic [22:0]  mem_rd_addr;
  logic         mem_rd_ack;
  logic         mem_rd_valid;
  logic [511:0] mem_rd_data;
  logic         db_update;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
  logic         err_unexp;

  db_load_responder #(
    .DATA_W(512), .LINE_SHIFT(9), .MEM_AW(23),
    .BASE_LINE(BASE), .DB_LINES(DBL)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .outAddress(outAddress),
    .loadDone(loadDone), .dataValid(dataValid), .inDB(inDB),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .db_update(db_update),
    .hit_count(hit_count), .miss_count(miss_count), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, cache contents, expected counters
  logic [511:0] mem_lines [0:7];
  bit           cv;
  int           ctag;
  logic [511:0] cdata;
  int           exp_hit;
  int           exp_miss;
  bit           exp_err;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_stats(input string tag);
    check({tag, ".hits"},   512'(hit_count),  512'(exp_hit));
    check({tag, ".misses"}, 512'(miss_count), 512'(exp_miss));
    check({tag, ".err"},    512'(err_unexp),  512'(exp_err));
  endtask

  // One load transaction. ack_dly: extra request cycles before the ack;
  // val_dly (>=1): cycles from the ack cycle to the read-data strobe;
  // upd: pulse db_update at the fill (miss) or at loadDone (hit);
  // keep: leave load high after dataValid.
  task automatic transact(input int line, input int ack_dly, input int val_dly,
                          input bit upd, input bit keep);
    logic [31:0]  addr;
    logic [511:0] exp_data;
    logic [511:0] got_data;
    bit oor, hit, addr_ok;
    int ld_n, dv_n, req_n, ld_cyc, dv_cyc, ack_cyc, exp_ld, exp_dv;
    addr = 32'(line * 512) + 32'($urandom_range(0, 511));
    oor  = line >= DBL;
    hit  = !oor && cv && (ctag == line);
    if (oor)      exp_data = '0;
    else if (hit) exp_data = cdata;
    else          exp_data = mem_lines[line + BASE];
    if (oor || hit) begin
      exp_ld = 1;
      exp_dv = 2;
    end else begin
      exp_ld = ack_dly + 2;
      exp_dv = ack_dly + 1 + val_dly + 1;
    end
    @(negedge clk);
    load = 1'b1;
    outAddress = addr;
    ld_n = 0; dv_n = 0; req_n = 0;
    ld_cyc = -1; dv_cyc = -1; ack_cyc = -1;
    addr_ok = 1'b1;
    got_data = '0;
    for (int cyc = 1; cyc <= 60 && dv_n == 0; cyc++) begin
      @(negedge clk);
      mem_rd_ack   = 1'b0;
      mem_rd_valid = 1'b0;
      db_update    = 1'b0;
      outAddress   = $urandom;
      if (loadDone) begin ld_n++; ld_cyc = cyc; end
      if (dataValid) begin dv_n++; dv_cyc = cyc; got_data = inDB; end
      if (mem_rd_req) begin
        req_n++;
        if (mem_rd_addr !== 23'(line + BASE)) addr_ok = 1'b0;
        if (ack_cyc < 0 && req_n == ack_dly + 1) begin
          mem_rd_ack = 1'b1;
          ack_cyc = cyc;
        end
      end
      if (ack_cyc >= 0 && cyc == ack_cyc + val_dly) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_lines[line + BASE];
        if (upd) db_update = 1'b1;
      end
      if (hit && upd && loadDone) db_update = 1'b1;
      if (dataValid && !keep) load = 1'b0;
    end
    // one cycle later: both strobes must have been single pulses
    @(negedge clk);
    mem_rd_valid = 1'b0;
    db_update    = 1'b0;
    check("ld_after", 512'(loadDone),  512'(0));
    check("dv_after", 512'(dataValid), 512'(0));
    // model update
    if (hit) begin
      exp_hit++;
      if (upd) cv = 1'b0;
    end else if (!oor) begin
      exp_miss++;
      if (upd) cv = 1'b0;
      else begin cv = 1'b1; ctag = line; cdata = exp_data; end
    end
    check("ld_count", 512'(ld_n),   512'(1));
    check("ld_cycle", 512'(ld_cyc), 512'(exp_ld));
    check("dv_cycle", 512'(dv_cyc), 512'(exp_dv));
    check("data",     got_data,     exp_data);
    check("inDB_hold", inDB,        exp_data);
    check("req_cycles", 512'(req_n), 512'((oor || hit) ? 0 : ack_dly + 1));
    check("mem_addr", 512'(addr_ok), 512'(1));
    check_stats("stats");
    $display("tx line=%0d kind=%s ack_dly=%0d val_dly=%0d upd=%0d ld@%0d dv@%0d hits=%0d misses=%0d",
             line, oor ? "oor" : (hit ? "hit" : "miss"), ack_dly, val_dly, upd,
             ld_cyc, dv_cyc, hit_count, miss_count);
  endtask

  task automatic model_reset();
    cv = 1'b0; ctag = 0; cdata = '0;
    exp_hit = 0; exp_miss = 0; exp_err = 1'b0;
  endtask

  initial begin
    logic [511:0] held;
    int held_ld, held_req;
    bit seen;
    for (int i = 0; i < 8; i++) mem_lines[i] = rand_line();
    rst = 1'b1; load = 1'b0; outAddress = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; db_update = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.loadDone", 512'(loadDone), 512'(0));
    check("rst.dataValid", 512'(dataValid), 512'(0));
    check("rst.inDB", inDB, 512'(0));
    check("rst.mem_req", 512'(mem_rd_req), 512'(0));
    check("rst.mem_addr", 512'(mem_rd_addr), 512'(0));
    check_stats("rst");

    // miss fetch of line 3, ack two cycles into the request, data three later
    transact(3, 1, 3, 1'b0, 1'b0);
    // hit on the same line with a different in-line offset
    transact(3, 0, 1, 1'b0, 1'b0);
    // out-of-range line returns zeros without touching memory
    transact(5, 0, 1, 1'b0, 1'b0);

    // invalidate, then the same line must be fetched again
    @(negedge clk); db_update = 1'b1;
    @(negedge clk); db_update = 1'b0;
    cv = 1'b0;
    transact(3, 0, 1, 1'b0, 1'b0);
    check("inval.misses", 512'(miss_count), 512'(2));

    // stray read data in IDLE: sticky error, inDB untouched
    held = inDB;
    @(negedge clk); mem_rd_valid = 1'b1; mem_rd_data = rand_line();
    @(negedge clk); mem_rd_valid = 1'b0;
    exp_err = 1'b1;
    check("stray.err", 512'(err_unexp), 512'(1));
    check("stray.inDB", inDB, held);

    // held load does not retrigger
    transact(1, 1, 2, 1'b0, 1'b1);
    held_ld = 0; held_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (loadDone) held_ld++;
      if (mem_rd_req) held_req++;
    end
    check("held.loadDone", 512'(held_ld), 512'(0));
    check("held.mem_req", 512'(held_req), 512'(0));
    @(negedge clk); load = 1'b0;
    transact(1, 0, 1, 1'b0, 1'b0);

    // randomized loads, occasional invalidations
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); db_update = 1'b1;
        @(negedge clk); db_update = 1'b0;
        cv = 1'b0;
      end
      transact($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(1, 4),
               $urandom_range(0, 4) == 0, 1'b0);
    end

    // reset while waiting for read data, then a late response
    @(negedge clk); load = 1'b1; outAddress = 32'(2 * 512);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd_req) begin seen = 1'b1; mem_rd_ack = 1'b1; end
    end
    check("rstmid.req_seen", 512'(seen), 512'(1));
    @(negedge clk); mem_rd_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    mem_rd_valid = 1'b1; mem_rd_data = rand_line();
    @(negedge clk); mem_rd_valid = 1'b0;
    @(negedge clk);
    check("rstmid.dataValid", 512'(dataValid), 512'(0));
    check("rstmid.loadDone", 512'(loadDone), 512'(0));
    check("rstmid.inDB", inDB, 512'(0));
    check("rstmid.mem_req", 512'(mem_rd_req), 512'(0));
    check_stats("rstmid");
    // cache must be empty: line 2 is fetched from memory again
    transact(2, 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
